// File: rtl/ibus_sched_pkg.sv
// Shared definitions for the ibus read scheduler.
//   state_t          : scheduler FSM encoding (IDLE, GRANT, RELEASE)
//   DEFAULT_MAX_WAIT : default number of port-0 grants a waiting secondary
//                      port tolerates before it is forced to win
package ibus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/ibus_sched_pick.sv
// Combinational winner selection for the ibus scheduler.
// Ports:
//   req_i     : per-port request vector (bit 0 = CPU ifetch)
//   starved_i : per-port "counter reached limit" flags (bit 0 ignored)
//   rr_i      : round-robin start index among ports 1..N-1
//   win_o     : one-hot winner, all zero when nothing is requested
// Order: starved secondary (lowest index) > port 0 > round-robin secondaries.
module sched_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  starved_i,
    input  logic [PW-1:0] rr_i,
    output logic [N-1:0]  win_o
);

    logic found;
    int   idx;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = 0;

        for (int i = 1; i < N; i++) begin
            if (!found && req_i[i] && starved_i[i]) begin
                win_o[i] = 1'b1;
                found    = 1'b1;
            end
        end

        if (!found && req_i[0]) begin
            win_o[0] = 1'b1;
            found    = 1'b1;
        end

        // Walk the secondaries starting at rr, wrapping N-1 back to 1.
        for (int k = 0; k < N - 1; k++) begin
            idx = int'(rr_i) + k;
            if (idx >= N) begin
                idx = idx - (N - 1);
            end
            for (int i = 1; i < N; i++) begin
                if (!found && (i == idx) && req_i[i]) begin
                    win_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ibus_sched.sv
// N-port scheduler in front of the single SPI flash read controller (ibus).
// Port 0 (CPU ifetch) has fixed priority; ports 1..N-1 share round-robin
// with a starvation limit so back-to-back ifetches cannot lock them out.
// Ports:
//   wb_clk, wb_rst : clock, asynchronous active-high reset
//   req_cyc/req_adr: per-port requests, address flattened AW bits per port
//   req_ack/req_rdt: per-port one-cycle ack, broadcast read data
//   x_cyc/x_adr    : request towards the ibus controller
//   x_ack/x_rdt    : controller response
//   grant          : one-hot owner of the current transaction
//   busy           : scheduler not idle
module ibus_sched
    import ibus_sched_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int AW       = 32
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic [N-1:0]    req_cyc,
    input  logic [AW*N-1:0] req_adr,
    output logic [N-1:0]    req_ack,
    output logic [31:0]     req_rdt,
    output logic            x_cyc,
    output logic [AW-1:0]   x_adr,
    input  logic            x_ack,
    input  logic [31:0]     x_rdt,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int PW = (N > 2) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            cyc_q, cyc_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q [1:N-1];
    logic [CW-1:0]   cnt_d [1:N-1];

    logic [N-1:0]    starved;
    logic [N-1:0]    pick;
    logic [AW-1:0]   pick_adr;
    logic [PW-1:0]   win_idx;

    assign starved[0] = 1'b0;

    for (genvar gi = 1; gi < N; gi++) begin : g_starved
        assign starved[gi] = (cnt_q[gi] == CW'(MAX_WAIT));
    end

    sched_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req_i     (req_cyc),
        .starved_i (starved),
        .rr_i      (rr_q),
        .win_o     (pick)
    );

    // Winner address and index, decoded from the one-hot pick.
    always_comb begin
        pick_adr = '0;
        win_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) begin
                pick_adr = req_adr[AW*i +: AW];
                win_idx  = PW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        rr_d    = rr_q;
        for (int i = 1; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            IDLE: begin
                if (|req_cyc) begin
                    state_d = GRANT;
                    grant_d = pick;
                    cyc_d   = 1'b1;
                    adr_d   = pick_adr;
                    if (pick[0]) begin
                        // Every secondary left waiting by an ifetch ages by one.
                        for (int i = 1; i < N; i++) begin
                            if (req_cyc[i] && (cnt_q[i] != CW'(MAX_WAIT))) begin
                                cnt_d[i] = cnt_q[i] + CW'(1);
                            end
                        end
                    end else begin
                        for (int i = 1; i < N; i++) begin
                            if (pick[i]) begin
                                cnt_d[i] = '0;
                            end
                        end
                        if (win_idx == PW'(N - 1)) begin
                            rr_d = PW'(1);
                        end else begin
                            rr_d = win_idx + PW'(1);
                        end
                    end
                end
            end
            GRANT: begin
                // The SPI read cannot be aborted, so only x_ack ends it.
                if (x_ack) begin
                    state_d = RELEASE;
                    cyc_d   = 1'b0;
                    grant_d = '0;
                end
            end
            RELEASE: begin
                // Gap cycle so a requester still holding req_cyc on the
                // ack edge is not granted again.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            rr_q    <= PW'(1);
            for (int i = 1; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            rr_q    <= rr_d;
            for (int i = 1; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Ack only a requester that is still asking; an abandoned request
    // completes on the x side silently.
    assign req_ack = {N{(state_q == GRANT) && x_ack}} & grant_q & req_cyc;
    assign req_rdt = x_rdt;
    assign x_cyc   = cyc_q;
    assign x_adr   = adr_q;
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ibus_sched.sv
module tb_ibus_sched;

    localparam int N        = 3;
    localparam int MAX_WAIT = 4;
    localparam int AW       = 32;

    logic            wb_clk = 1'b0;
    logic            wb_rst;
    logic [N-1:0]    req_cyc;
    logic [AW*N-1:0] req_adr;
    logic [N-1:0]    req_ack;
    logic [31:0]     req_rdt;
    logic            x_cyc;
    logic [AW-1:0]   x_adr;
    logic            x_ack;
    logic [31:0]     x_rdt;
    logic [N-1:0]    grant;
    logic            busy;

    ibus_sched #(.N(N), .MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
        .wb_clk  (wb_clk),
        .wb_rst  (wb_rst),
        .req_cyc (req_cyc),
        .req_adr (req_adr),
        .req_ack (req_ack),
        .req_rdt (req_rdt),
        .x_cyc   (x_cyc),
        .x_adr   (x_adr),
        .x_ack   (x_ack),
        .x_rdt   (x_rdt),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic [N-1:0]  grant;
        logic [AW-1:0] adr;
        int            cyc;
    } gexp_t;

    typedef struct {
        logic [N-1:0] ack;
        logic [31:0]  rdt;
        int           cyc;
    } aexp_t;

    gexp_t gq[$];
    aexp_t aq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge wb_clk) cyc <= cyc + 1;

    // Reference model: transaction-level view of the arbitration rules.
    bit            pend [N];
    logic [AW-1:0] padr [N];
    logic [AW-1:0] nadr [N];
    int            mcnt [N];
    int            mrr;

    logic exp_xcyc;
    logic exp_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    function automatic bit any_pend();
        bit a;
        a = 0;
        for (int i = 0; i < N; i++) a |= pend[i];
        return a;
    endfunction

    function automatic int model_pick();
        int i;
        for (int s = 1; s < N; s++)
            if (pend[s] && mcnt[s] == MAX_WAIT) return s;
        if (pend[0]) return 0;
        for (int k = 0; k < N - 1; k++) begin
            i = 1 + ((mrr - 1 + k) % (N - 1));
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        if (w == 0) begin
            for (int s = 1; s < N; s++)
                if (pend[s] && mcnt[s] < MAX_WAIT) mcnt[s]++;
        end else begin
            mcnt[w] = 0;
            mrr     = 1 + (w % (N - 1));
        end
    endtask

    task automatic model_reset();
        mrr = 1;
        for (int i = 0; i < N; i++) begin
            mcnt[i] = 0;
            pend[i] = 0;
        end
    endtask

    task automatic raise(input int i);
        pend[i]              = 1;
        padr[i]              = nadr[i];
        req_cyc[i]           = 1'b1;
        req_adr[AW*i +: AW]  = nadr[i];
        nadr[i]              = $urandom;
    endtask

    // Called just after a posedge with the DUT in IDLE; returns in IDLE.
    task automatic do_round(input logic [N-1:0] new_req, input int lat, input logic [31:0] rdt,
                            input bit abandon, input bit spurious, input logic [N-1:0] mid_req);
        int w;
        int rem;
        for (int i = 0; i < N; i++)
            if (new_req[i] && !pend[i]) raise(i);
        if (!any_pend()) begin
            x_ack = spurious;
            x_rdt = $urandom;
            @(posedge wb_clk) #1;
            x_ack = 1'b0;
            return;
        end
        w = model_pick();
        model_grant(w);
        gq.push_back('{onehot(w), padr[w], cyc + 1});
        @(posedge wb_clk) #1;
        exp_xcyc = 1'b1;
        exp_busy = 1'b1;
        for (int i = 0; i < N; i++)
            if (mid_req[i] && !pend[i]) raise(i);
        rem = lat;
        if (abandon && lat >= 1) begin
            @(posedge wb_clk) #1;
            req_cyc[w] = 1'b0;
            pend[w]    = 0;
            rem        = lat - 1;
        end
        repeat (rem) @(posedge wb_clk) #1;
        x_ack = 1'b1;
        x_rdt = rdt;
        if (pend[w]) aq.push_back('{onehot(w), rdt, cyc});
        @(posedge wb_clk) #1;
        x_ack = spurious;
        x_rdt = $urandom;
        if (pend[w]) begin
            req_cyc[w] = 1'b0;
            pend[w]    = 0;
        end
        exp_xcyc = 1'b0;
        @(posedge wb_clk) #1;
        x_ack    = 1'b0;
        exp_busy = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && any_pend(); k++)
            do_round('0, $urandom_range(0, 3), $urandom, 0, 0, '0);
        check("drain_empty", 64'(any_pend()), 64'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or an ack.
    logic          prev_xcyc = 1'b0;
    logic [N-1:0]  cur_grant = '0;
    logic [AW-1:0] cur_adr   = '0;
    gexp_t         g;
    aexp_t         a;

    always @(negedge wb_clk) begin
        check("x_cyc", 64'(x_cyc), 64'(exp_xcyc));
        check("busy", 64'(busy), 64'(exp_busy));
        if (x_cyc && !prev_xcyc) begin
            if (gq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL grant_unexpected: got grant=%b adr=%h expected no transaction", grant, x_adr);
            end else begin
                g = gq.pop_front();
                check("grant", 64'(grant), 64'(g.grant));
                check("x_adr", 64'(x_adr), 64'(g.adr));
                check("grant_cycle", 64'(cyc), 64'(g.cyc));
                cur_grant <= g.grant;
                cur_adr   <= g.adr;
            end
        end else if (x_cyc) begin
            check("grant_hold", 64'(grant), 64'(cur_grant));
            check("x_adr_hold", 64'(x_adr), 64'(cur_adr));
        end else begin
            check("grant_idle", 64'(grant), 64'd0);
        end
        if (req_ack != '0) begin
            if (aq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected: got req_ack=%b expected none", req_ack);
            end else begin
                a = aq.pop_front();
                check("req_ack", 64'(req_ack), 64'(a.ack));
                check("req_rdt", 64'(req_rdt), 64'(a.rdt));
                check("ack_cycle", 64'(cyc), 64'(a.cyc));
            end
        end
        prev_xcyc <= x_cyc;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] m;
        logic [N-1:0] mid;
        int           lat;
        int           w;

        wb_rst   = 1'b1;
        req_cyc  = '0;
        req_adr  = '0;
        x_ack    = 1'b0;
        x_rdt    = '0;
        exp_xcyc = 1'b0;
        exp_busy = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) nadr[i] = $urandom;

        #1;
        check("rst_x_cyc", 64'(x_cyc), 64'd0);
        check("rst_x_adr", 64'(x_adr), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_req_ack", 64'(req_ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 1'b0;

        // Single request, long latency.
        nadr[1] = 32'h4000_0000;
        do_round(3'b010, 20, 32'hFFFF_FFFF, 0, 0, '0);

        // Priority: ports 0 and 1 together.
        do_round(3'b011, 3, $urandom, 0, 0, '0);
        drain();

        // Starvation: port 0 re-requests every round, port 2 held.
        repeat (6) do_round(3'b101, 2, $urandom, 0, 0, '0);
        drain();

        // Round-robin between ports 1 and 2.
        repeat (4) do_round(3'b110, 1, $urandom, 0, 0, '0);
        drain();

        // Abandoned request.
        do_round(3'b010, 5, $urandom, 1, 0, '0);
        drain();

        // Randomized traffic.
        repeat (250) begin
            m[0] = ($urandom_range(0, 9) < 7);
            for (int i = 1; i < N; i++) m[i] = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < N; i++) mid[i] = ($urandom_range(0, 9) < 2);
            lat = $urandom_range(0, 6);
            do_round(m, lat, $urandom, (lat >= 1) && ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 4) == 0), mid);
        end
        drain();

        // Reset mid-GRANT: first move the rr pointer away from 1.
        do_round(3'b010, 1, $urandom, 0, 0, '0);
        raise(0);
        w = model_pick();
        model_grant(w);
        gq.push_back('{onehot(w), padr[w], cyc + 1});
        @(posedge wb_clk) #1;
        exp_xcyc = 1'b1;
        exp_busy = 1'b1;
        @(posedge wb_clk) #3;
        wb_rst   = 1'b1;
        exp_xcyc = 1'b0;
        exp_busy = 1'b0;
        #1;
        check("arst_x_cyc", 64'(x_cyc), 64'd0);
        check("arst_grant", 64'(grant), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        req_cyc = '0;
        model_reset();
        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 1'b0;
        do_round(3'b110, 2, $urandom, 0, 0, '0);
        do_round(3'b001, 2, $urandom, 0, 0, '0);
        drain();

        repeat (2) @(posedge wb_clk);
        #1;
        check("grant_queue_empty", 64'(gq.size()), 64'd0);
        check("ack_queue_empty", 64'(aq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibus_sched.md
Name: ibus_sched

Overview:
- N-port scheduler sharing the single SPI flash read controller (ibus) between the CPU instruction bus and N-1 secondary readers (dbus bridge, future prefetch/DMA readers).
- Port 0 (CPU ifetch) has fixed priority. Ports 1..N-1 are served round-robin, with a starvation limit so a secondary port is never blocked indefinitely by back-to-back ifetches.
- Sits between the requesters and the ibus controller's x_* Wishbone-style read interface. It replaces the 2-way arbiter wherever more than two readers exist.

Parameters:
- N, 3, number of requester ports (2..8); port 0 is high priority.
- MAX_WAIT, 4, number of consecutive port-0 grants a waiting secondary port tolerates before it wins the next arbitration.
- AW, 32, address width.

Ports:
- wb_clk  in  1  system clock
- wb_rst  in  1  asynchronous reset, active high
- req_cyc  in  N  per-port read request, held until its ack
- req_adr  in  AW*N  per-port address, flattened; port i occupies bits [AW*i +: AW]
- req_ack  out  N  per-port one-cycle ack
- req_rdt  out  32  read data, broadcast to all ports, valid with req_ack
- x_cyc  out  1  request to the ibus controller
- x_adr  out  AW  address to the ibus controller
- x_ack  in  1  controller ack, one cycle
- x_rdt  in  32  controller read data
- grant  out  N  one-hot owner of the current transaction, 0 when idle
- busy  out  1  high whenever the scheduler is not IDLE

Behaviour:
- Reset (async, immediate): state IDLE; x_cyc=0, x_adr=0, grant=0, req_ack=0, busy=0; rr pointer=1; all starvation counters=0.
- States:
  - IDLE: arbitrate sampled req_cyc.
  - GRANT: x_cyc high, wait for x_ack.
  - RELEASE: one-cycle gap.
- IDLE->GRANT at the edge where any req_cyc is high. At that edge: grant, x_adr (latched from the winner's req_adr) and x_cyc=1 are registered. x_cyc therefore rises one cycle after the request is sampled.
- Arbitration order:
  1. Any secondary port whose counter equals MAX_WAIT; lowest index first if several.
  2. Port 0.
  3. Secondary ports round-robin, starting at the rr pointer, wrapping from N-1 to 1.
- Round-robin pointer: after a secondary grant, rr = winner+1, wrapping N-1 -> 1. A port-0 grant leaves rr unchanged.
- Starvation counter, per secondary port:
  - increments, saturating at MAX_WAIT, on each port-0 grant while that port's req_cyc is high;
  - clears when that port is granted.
- GRANT: x_cyc and x_adr are held stable until x_ack, regardless of requester behaviour, because the controller cannot abort an SPI read.
- On x_ack:
  - req_ack[g] = x_ack & req_cyc[g], combinational, same cycle;
  - req_rdt = x_rdt passes through;
  - the next edge registers x_cyc=0, grant=0 and state RELEASE.
- RELEASE: lasts one cycle, then IDLE.
  - Requesters drop req_cyc on the edge where they see ack, so the gap stops a stale req_cyc from re-granting the same port.
  - RELEASE performs no arbitration.
- Requester drops req_cyc before ack (protocol violation): the transaction still completes on the x side; req_ack is suppressed; return to IDLE normally.
- Minimum turnaround: back-to-back requests from different ports give x_cyc low for exactly 2 cycles (RELEASE + IDLE).
- x_ack outside GRANT is ignored.
- busy = (state != IDLE).
- Reset during GRANT: all outputs clear asynchronously; the ibus controller is on the same reset, so no dangling transaction.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2;
  - default MAX_WAIT.
- One combinational sub-module, sched_pick:
  - inputs: req vector, starved vector, rr pointer;
  - output: one-hot winner;
  - unit-testable on its own.
- Counters, pointer and FSM stay in ibus_sched.

Test Plan:
- Single request: port 1 requests adr 0x4000_0000, x_ack after 20 cycles with x_rdt=0xFFFFFFFF -> x_cyc rises 1 cycle after req; x_adr=0x4000_0000; req_ack[1] for 1 cycle; req_rdt=0xFFFFFFFF; busy low 2 cycles after ack.
- Priority: ports 0 and 1 request in the same cycle -> grant=3'b001 first; port 1 is granted after port 0's RELEASE+IDLE; req_ack[1] only after its own x_ack.
- Starvation: port 0 re-requests immediately after every ack, port 2 held high, MAX_WAIT=4 -> exactly 4 port-0 grants, then grant=3'b100; port 2's counter then reads 0.
- Round-robin: ports 1 and 2 held high continuously, port 0 idle -> grant sequence 1,2,1,2.
- Abandoned request: port 1 drops req_cyc mid-GRANT -> x_cyc stays high until x_ack; req_ack stays 0; state returns to IDLE.
- Reset mid-GRANT: wb_rst pulsed for 3 cycles -> x_cyc, grant and busy go 0 without waiting for a clock edge; after release a new port-0 request is served normally with a fresh rr=1.
